// File: rtl/pcihellocore_led_sequencer.sv
// pcihellocore_led_sequencer
//
// Autonomous pattern sequencer for the 32-bit red-LED PIO output register.
// The PCIe host programs it through a small Avalon-MM CSR slave. The block
// steps the LED pattern (static, blink, rotate left, rotate right) at a
// programmable rate. Every change of the displayed pattern is forwarded to
// the PIO s1 port as a single one-cycle Avalon-MM write.
//
// Ports
//   clk, reset_n         clock; asynchronous active-low reset
//   s_address[1:0]       CSR select: 0 CTRL, 1 PATTERN, 2 PERIOD, 3 STATUS
//   s_chipselect         CSR access strobe
//   s_write_n            active-low write qualifier
//   s_writedata[31:0]    CSR write data
//   s_readdata[31:0]     CSR read data, combinational from s_address
//   m_address[1:0]       PIO address (always 0, the data register)
//   m_chipselect         PIO write strobe, registered
//   m_write_n            active-low PIO write, registered (== !m_chipselect)
//   m_writedata[31:0]    pattern written to the PIO, registered
//   dbg_state[1:0]       current sequencer state (IDLE/HOLD/STEP)
//
// Handshake: neither bus has flow control. A CSR write is accepted in every
// cycle where s_chipselect && !s_write_n. Reads complete in the same cycle.
// The PIO has no waitrequest, so a strobe on m_chipselect is consumed in the
// cycle it is asserted. Strobes may therefore appear on consecutive cycles.

module pcihellocore_led_sequencer #(
    parameter int                     PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0]    DEFAULT_PERIOD = PERIOD_W'(5000000),
    parameter logic [31:0]            RESET_PATTERN  = 32'h00FFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTL   = 2'd2;
    localparam logic [1:0] MODE_ROTR   = 2'd3;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_PATTERN = 2'd1;
    localparam logic [1:0] A_PERIOD  = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    logic                ctrl_en;
    logic [1:0]          ctrl_mode;
    logic [31:0]         pattern;
    logic [PERIOD_W-1:0] period;
    logic [31:0]         cur;
    logic [PERIOD_W-1:0] presc;
    logic [15:0]         step_cnt;

    logic                wr;
    logic                wr_ctrl;
    logic                wr_pattern;
    logic                wr_period;
    logic                en_change;
    logic                host_event;
    logic [1:0]          state;
    logic                running;
    logic [PERIOD_W-1:0] period_m1;
    logic                tick;
    logic                pend;
    logic [31:0]         next_cur;
    logic [31:0]         cur_d;

    assign wr         = s_chipselect && !s_write_n;
    assign wr_ctrl    = wr && (s_address == A_CTRL);
    assign wr_pattern = wr && (s_address == A_PATTERN);
    assign wr_period  = wr && (s_address == A_PERIOD);
    assign en_change  = wr_ctrl && (s_writedata[0] != ctrl_en);

    // Host events reload cur and restart the prescaler. They win over a
    // tick that lands in the same cycle.
    assign host_event = wr_pattern || en_change;

    // The state is a pure function of CTRL. There is no hidden sequencing.
    always_comb begin
        state = ST_IDLE;
        if (ctrl_en) begin
            state = (ctrl_mode == MODE_STATIC) ? ST_HOLD : ST_STEP;
        end
    end

    assign running   = (state == ST_STEP);
    assign dbg_state = state;

    // PERIOD=0 behaves like PERIOD=1: a step every cycle. The >= compare
    // lets a shrinking PERIOD take effect immediately, even when presc is
    // already past the new limit.
    assign period_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign tick      = running && (presc >= period_m1);

    always_comb begin
        next_cur = cur;
        case (ctrl_mode)
            MODE_BLINK:  next_cur = (cur == 32'h0) ? pattern : 32'h0;
            MODE_ROTL:   next_cur = {cur[30:0], cur[31]};
            MODE_ROTR:   next_cur = {cur[0], cur[31:1]};
            default:     next_cur = cur;
        endcase
    end

    always_comb begin
        cur_d = cur;
        if (wr_pattern) begin
            cur_d = s_writedata;
        end else if (en_change) begin
            cur_d = pattern;
        end else if (tick) begin
            cur_d = next_cur;
        end
    end

    // pend flags a change of cur this cycle. It becomes the PIO strobe on
    // the following cycle.
    assign pend = host_event || tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_STATIC;
            pattern   <= RESET_PATTERN;
            period    <= DEFAULT_PERIOD;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= s_writedata[0];
                ctrl_mode <= s_writedata[2:1];
            end
            if (wr_pattern) begin
                pattern <= s_writedata;
            end
            if (wr_period) begin
                period <= s_writedata[PERIOD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= RESET_PATTERN;
            presc    <= '0;
            step_cnt <= 16'h0;
        end else begin
            cur <= cur_d;
            if (host_event || !running || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PERIOD_W'(1);
            end
            if (tick && !host_event) begin
                step_cnt <= step_cnt + 16'h1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= RESET_PATTERN;
        end else begin
            m_chipselect <= pend;
            m_write_n    <= !pend;
            if (pend) begin
                m_writedata <= cur_d;
            end
        end
    end

    assign m_address = 2'd0;

    always_comb begin
        s_readdata = 32'h0;
        case (s_address)
            A_CTRL:    s_readdata = {29'h0, ctrl_mode, ctrl_en};
            A_PATTERN: s_readdata = pattern;
            A_PERIOD:  s_readdata = 32'(period);
            A_STATUS:  s_readdata = {step_cnt, 15'h0, running};
            default:   s_readdata = 32'h0;
        endcase
    end

endmodule
